ad7276_axis_packer: RTL and testbench
=====================================

# ad7276_axis_packer

Downstream stage of the AD7276 dual-channel interface. Takes each completed conversion pair (two 12-bit samples plus a ready strobe), buffers it in a small FIFO, and emits it as one 32-bit AXI4-Stream beat. `m_axis_tlast` marks packet boundaries for the DMA. The block sits between the ADC interface and the AXI-Stream DMA/interconnect, entirely in the FPGA clock domain.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: sample-pair buffer depth; power of two, at least 4.
- `PACKET_LEN`, 256: beats per packet; `m_axis_tlast` on the last beat; at least 1.

Ports:
- `fpga_clk_i`  in  1: single clock for the block.
- `reset_n_i`  in  1: reset, synchronous, active-low.
- `en_0_i`, `en_1_i`  in  1 each: channel enables, same signals that drive the ADC interface.
- `data_rdy_i`  in  1: conversion-ready strobe. It may be a glitchy/foreign-clock derived level, so it is treated as asynchronous.
- `data_0_i`, `data_1_i`  in  12 each: held sample values, stable from `data_rdy_i` rise until the next conversion.
- `m_axis_tdata`  out  32: packed sample pair.
- `m_axis_tvalid`  out  1: beat valid.
- `m_axis_tready`  in  1: downstream ready.
- `m_axis_tlast`  out  1: last beat of packet.
- `overflow_o`  out  1: sticky flag; a sample pair was dropped.
- `clr_ovf_i`  in  1: clears `overflow_o`.

## Operation
- **Strobe synchronisation:** `data_rdy_i` passes through a 2-flop synchroniser (s1, s2), then a third flop s3. `capture = s2 & ~s3`, a one-cycle rising-edge pulse. A level held high for many cycles yields exactly one capture.
- **Capture:** on `capture`, if `en_0_i | en_1_i`, push one word.
  - If both enables are low, the pulse is ignored silently; `overflow_o` is unaffected.
- **Word format:**
  - [31] = `en_1_i`, [30:28] = 0, [27:16] = `data_1_i`, or 0 if `en_1_i` is low.
  - [15] = `en_0_i`, [14:12] = 0, [11:0] = `data_0_i`, or 0 if `en_0_i` is low.
  - Enables and data are sampled on the push edge.
- **FIFO:** synchronous, first-word fall-through.
  - `m_axis_tvalid` = not empty; `m_axis_tdata` = head word.
  - Pop on `m_axis_tvalid & m_axis_tready`.
  - Push is accepted when not full, or when full with a simultaneous pop.
  - Otherwise the push is dropped and `overflow_o` is set.
- **Overflow:** `overflow_o` sets the cycle after a dropped push.
  - It clears the cycle after `clr_ovf_i` is high.
  - A drop coincident with `clr_ovf_i` wins: the flag stays set.
- **Packet counter:** `beat_cnt`, width clog2(`PACKET_LEN`), minimum 1.
  - Increments on each output handshake and wraps to 0 after `PACKET_LEN`-1.
  - `m_axis_tlast = (beat_cnt == PACKET_LEN-1)`, combinational from the counter, valid whenever `m_axis_tvalid` is high.
  - Dropped samples do not advance the counter. Enable changes do not reset it.
- **AXI rules:** once `m_axis_tvalid` is high, it stays high, with `m_axis_tdata` and `m_axis_tlast` stable, until the handshake. `m_axis_tvalid` never depends combinationally on `m_axis_tready`.
- **Reset (including mid-packet):**
  - Clears the FIFO pointers, `beat_cnt`, s1–s3, and `overflow_o`.
  - `m_axis_tvalid` = 0 and `m_axis_tlast` = 0 after the reset edge; `m_axis_tdata` is don't-care while `m_axis_tvalid` = 0.
  - A `data_rdy_i` level already high when reset releases produces a capture about 3 cycles later. This is intended: one sample is taken.

## Timing
- **Clock edges:** edge 1 = the first `fpga_clk_i` edge that samples `data_rdy_i` high.
  - s2 is high after edge 2, so `capture` is high between edges 2 and 3.
  - The push happens at edge 3.
  - With the FIFO empty, `m_axis_tvalid` is high after edge 3. Latency is 3 cycles.
- **Throughput:** one push and one pop per cycle. With `m_axis_tready` held high, the FIFO never holds more than 1 word.
- **Minimum strobe spacing:** 2 low cycles of s2 between captures. The ADC frame (≥1 µs at 100 MHz) exceeds this.

## Structure
- **Shared package `ad7276_pkg`:**
  - `AD7276_SAMPLE_W` = 12.
  - `AD7276_AXIS_W` = 32.
  - Word field bit positions as localparams; also used by software-side models.
- **Sub-module `axis_sample_fifo`:** generic sync FWFT FIFO with parameters WIDTH and DEPTH, ports push/full/pop/empty/dout, and registered pointers with an extra wrap bit for full/empty.
- **Top-level contents:** synchroniser and edge detect, push/overflow logic, packet counter, output assigns.

## Test plan
- **Single capture:** `en_0`=1, `en_1`=1, `data_0`=0x123, `data_1`=0xABC, `data_rdy` pulsed, tready=1 → one beat 0x8ABC8123 with tvalid 3 cycles after the strobe; tlast=0.
- **Channel masking:** `en_0`=1, `en_1`=0, `data_1`=0xFFF, `data_0`=0x055 → tdata 0x00008055. Both enables 0 → no beat and `overflow_o` stays 0.
- **Packet boundary:** `PACKET_LEN`=4, 9 strobes, tready=1 → tlast on beats 4 and 8 only; beat 9 has tlast=0.
- **Overflow:** `FIFO_DEPTH`=4, tready=0, 6 strobes → 4 words held, `overflow_o`=1. Then `clr_ovf_i` → 0. Release tready → exactly 4 beats out, in order.
- **Backpressure stability:** tready toggled randomly for 50 strobes → tdata and tlast never change while tvalid=1 and tready=0; no words lost or duplicated, verified against a scoreboard.
- **Reset mid-packet:** `reset_n_i` low for 1 cycle with 3 words queued and `beat_cnt`=2 → tvalid=0 the next cycle; the next capture emits tlast after a full `PACKET_LEN` beats.

Source files
------------

// File: rtl/ad7276_pkg.sv
// Shared definitions for the AD7276 capture path: sample/bus widths, packed-word
// field positions and the word packing helper.
package ad7276_pkg;

   localparam int unsigned AD7276_SAMPLE_W = 12;
   localparam int unsigned AD7276_AXIS_W   = 32;

   localparam int unsigned CH0_DATA_LSB = 0;
   localparam int unsigned CH0_EN_BIT   = 15;
   localparam int unsigned CH1_DATA_LSB = 16;
   localparam int unsigned CH1_EN_BIT   = 31;

   // Disabled channels contribute a zero data field; reserved bits stay zero.
   function automatic logic [AD7276_AXIS_W-1:0] ad7276_pack(
      input logic                       en0,
      input logic                       en1,
      input logic [AD7276_SAMPLE_W-1:0] d0,
      input logic [AD7276_SAMPLE_W-1:0] d1
   );
      logic [AD7276_AXIS_W-1:0] w;
      w                                      = '0;
      w[CH1_EN_BIT]                          = en1;
      w[CH1_DATA_LSB +: AD7276_SAMPLE_W]     = en1 ? d1 : '0;
      w[CH0_EN_BIT]                          = en0;
      w[CH0_DATA_LSB +: AD7276_SAMPLE_W]     = en0 ? d0 : '0;
      return w;
   endfunction

endpackage

// File: rtl/ad7276_axis_packer_if.sv
// AXI4-Stream beat bundle (data/valid/ready/last) for the packer output.
interface ad7276_axis_if;
   import ad7276_pkg::*;

   logic [AD7276_AXIS_W-1:0] tdata;
   logic                     tvalid;
   logic                     tready;
   logic                     tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_sample_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry an extra wrap bit so
// full and empty are told apart without a separate occupancy count.
module axis_sample_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   output logic             full_o,
   input  logic             pop_i,
   output logic             empty_o,
   output logic [WIDTH-1:0] dout_c_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             full_q, empty_q;
   logic             push_ok_c, pop_ok_c;
   logic [WIDTH-1:0] mem_q [DEPTH];

   // A push into a full FIFO is still taken when the head leaves on the same edge.
   assign pop_ok_c  = pop_i & ~empty_q;
   assign push_ok_c = push_i & (~full_q | pop_ok_c);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok_c) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_ok_c)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   // Flags are registered from the next pointers so they line up with the pointers.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         empty_q  <= (wr_ptr_d == rd_ptr_d);
         full_q   <= ((wr_ptr_d ^ rd_ptr_d) == {1'b1, {AW{1'b0}}});
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok_c) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

   assign dout_c_o = mem_q[rd_ptr_q[AW-1:0]];
   assign full_o   = full_q;
   assign empty_o  = empty_q;

endmodule

// File: rtl/ad7276_axis_packer.sv
// Packs each AD7276 conversion pair into one 32-bit AXI4-Stream beat, buffered in
// a small FWFT FIFO, with packet framing via tlast and a sticky drop flag.
module ad7276_axis_packer
   import ad7276_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned PACKET_LEN = 256
) (
   input  logic                       fpga_clk_i,
   input  logic                       reset_n_i,
   input  logic                       en_0_i,
   input  logic                       en_1_i,
   input  logic                       data_rdy_i,
   input  logic [AD7276_SAMPLE_W-1:0] data_0_i,
   input  logic [AD7276_SAMPLE_W-1:0] data_1_i,
   input  logic                       clr_ovf_i,
   output logic                       overflow_o,
   ad7276_axis_if.master              m_axis
);
   localparam int unsigned CNT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;

   logic                     s1_q, s2_q, s3_q;
   logic                     capture_c, push_req_c, pop_c, drop_c, last_c;
   logic                     fifo_full, fifo_empty;
   logic [AD7276_AXIS_W-1:0] word_c, head_c;
   logic                     overflow_q, overflow_d;
   logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;

   // data_rdy_i is asynchronous: two synchroniser stages, third stage for edge detect.
   always_ff @(posedge fpga_clk_i) begin
      if (!reset_n_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= data_rdy_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign capture_c  = s2_q & ~s3_q;
   assign push_req_c = capture_c & (en_0_i | en_1_i);
   assign pop_c      = ~fifo_empty & m_axis.tready;
   assign drop_c     = push_req_c & fifo_full & ~pop_c;
   assign word_c     = ad7276_pack(en_0_i, en_1_i, data_0_i, data_1_i);
   assign last_c     = (beat_cnt_q == CNT_W'(PACKET_LEN - 1));

   axis_sample_fifo #(
      .WIDTH (AD7276_AXIS_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i    (fpga_clk_i),
      .rst_n_i  (reset_n_i),
      .push_i   (push_req_c),
      .din_i    (word_c),
      .full_o   (fifo_full),
      .pop_i    (pop_c),
      .empty_o  (fifo_empty),
      .dout_c_o (head_c)
   );

   // A drop on the same edge as a clear request keeps the flag set.
   always_comb begin
      overflow_d = overflow_q;
      beat_cnt_d = beat_cnt_q;
      if (drop_c)         overflow_d = 1'b1;
      else if (clr_ovf_i) overflow_d = 1'b0;
      if (pop_c)          beat_cnt_d = last_c ? '0 : beat_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge fpga_clk_i) begin
      if (!reset_n_i) begin
         overflow_q <= 1'b0;
         beat_cnt_q <= '0;
      end else begin
         overflow_q <= overflow_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign overflow_o    = overflow_q;
   assign m_axis.tvalid = ~fifo_empty;
   assign m_axis.tdata  = head_c;
   assign m_axis.tlast  = ~fifo_empty & last_c;

endmodule

// File: tb/tb_ad7276_axis_packer.sv
// Bench for ad7276_axis_packer: directed and random strobes checked cycle by
// cycle against a queue-based model of the packer's observable behaviour.
module tb_ad7276_axis_packer;
   localparam int DEPTH = 4;
   localparam int LEN   = 4;

   logic        clk = 1'b0;
   logic        rst_n, en0, en1, rdy, clr, ovf;
   logic [11:0] d0, d1;

   always #5 clk = ~clk;

   ad7276_axis_if axis ();

   ad7276_axis_packer #(.FIFO_DEPTH(DEPTH), .PACKET_LEN(LEN)) dut (
      .fpga_clk_i (clk),
      .reset_n_i  (rst_n),
      .en_0_i     (en0),
      .en_1_i     (en1),
      .data_rdy_i (rdy),
      .data_0_i   (d0),
      .data_1_i   (d1),
      .clr_ovf_i  (clr),
      .overflow_o (ovf),
      .m_axis     (axis)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] mq[$];
   int          beats = 0;
   bit          ovf_m = 1'b0;
   int          push_in = -1;
   bit          rdy_prev = 1'b0;
   bit          armed = 1'b0;
   bit          rand_ready = 1'b0;
   bit          hold_prev = 1'b0;
   logic [31:0] data_prev;
   logic        last_prev;
   int          hs_obs = 0;
   int          last_obs = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input bit e0, input bit e1,
                                              input logic [11:0] a0, input logic [11:0] a1);
      logic [31:0] w;
      w = 32'd0;
      if (e1) w = w | 32'h8000_0000 | ({20'd0, a1} << 16);
      if (e0) w = w | 32'h0000_8000 | {20'd0, a0};
      return w;
   endfunction

   // One clock: check outputs at the falling edge, advance the model to the next rising edge.
   task automatic step();
      bit          fire, pop, any, drop;
      logic [31:0] w;
      if (rand_ready) axis.tready = 1'($urandom_range(0, 1));
      if (armed) begin
         chk("tvalid", 32'(axis.tvalid), 32'(mq.size() != 0));
         if (mq.size() != 0) chk("tdata", axis.tdata, mq[0]);
         chk("tlast", 32'(axis.tlast), 32'(mq.size() != 0 && (beats % LEN) == LEN - 1));
         chk("overflow", 32'(ovf), 32'(ovf_m));
         if (hold_prev) begin
            chk("hold_valid", 32'(axis.tvalid), 32'd1);
            chk("hold_data", axis.tdata, data_prev);
            chk("hold_last", 32'(axis.tlast), 32'(last_prev));
         end
      end
      hold_prev = armed && rst_n && axis.tvalid === 1'b1 && axis.tready === 1'b0;
      data_prev = axis.tdata;
      last_prev = axis.tlast;
      if (armed && rst_n && axis.tvalid === 1'b1 && axis.tready === 1'b1) begin
         hs_obs++;
         if (axis.tlast === 1'b1) last_obs++;
      end
      // Push lands on the third rising edge after the strobe is first seen high.
      fire = (push_in == 0);
      if (push_in >= 0) push_in--;
      if (!rst_n) begin
         mq.delete();
         beats     = 0;
         ovf_m     = 1'b0;
         push_in   = -1;
         hold_prev = 1'b0;
      end else begin
         if (rdy && !rdy_prev) push_in = 1;
         pop  = (mq.size() != 0) && axis.tready;
         any  = en0 | en1;
         w    = model_word(en0, en1, d0, d1);
         drop = fire && any && mq.size() >= DEPTH && !pop;
         if (pop) begin
            void'(mq.pop_front());
            beats++;
         end
         if (fire && any && !drop) mq.push_back(w);
         if (drop) ovf_m = 1'b1;
         else if (clr) ovf_m = 1'b0;
      end
      rdy_prev = rst_n ? rdy : 1'b0;
      @(posedge clk);
      if (!rst_n) armed = 1'b1;
      @(negedge clk);
   endtask

   task automatic strobe(input bit e0, input bit e1, input logic [11:0] a0, input logic [11:0] a1);
      en0 = e0; en1 = e1; d0 = a0; d1 = a1;
      rdy = 1'b1;
      step();
      rdy = 1'b0;
      repeat (3) step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; rdy = 1'b0; clr = 1'b0;
      d0 = 12'd0; d1 = 12'd0; axis.tready = 1'b0;
      @(negedge clk);
      do_reset();
      step();
      chk("reset_valid", 32'(axis.tvalid), 32'd0);
      chk("reset_last", 32'(axis.tlast), 32'd0);
      chk("reset_ovf", 32'(ovf), 32'd0);

      // Single capture, held at the head then released.
      strobe(1'b1, 1'b1, 12'h123, 12'hABC);
      chk("single_word", axis.tdata, 32'h8ABC_8123);
      chk("single_last", 32'(axis.tlast), 32'd0);
      axis.tready = 1'b1;
      repeat (2) step();

      // Channel masking and the both-disabled case.
      axis.tready = 1'b0;
      strobe(1'b1, 1'b0, 12'h055, 12'hFFF);
      chk("mask_word", axis.tdata, 32'h0000_8055);
      axis.tready = 1'b1;
      repeat (2) step();
      strobe(1'b0, 1'b0, 12'h321, 12'h654);
      repeat (2) step();
      chk("none_valid", 32'(axis.tvalid), 32'd0);
      chk("none_ovf", 32'(ovf), 32'd0);

      // Packet framing from a fresh counter.
      do_reset();
      axis.tready = 1'b1;
      hs_obs = 0; last_obs = 0;
      for (int i = 0; i < 9; i++) strobe(1'b1, 1'b1, 12'($urandom), 12'($urandom));
      repeat (2) step();
      chk("pkt_beats", 32'(hs_obs), 32'd9);
      chk("pkt_lasts", 32'(last_obs), 32'd2);

      // Overflow with the sink stalled, then clear and drain.
      do_reset();
      axis.tready = 1'b0;
      for (int i = 0; i < 6; i++) strobe(1'b1, 1'b1, 12'($urandom), 12'($urandom));
      chk("ovf_set", 32'(ovf), 32'd1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      step();
      chk("ovf_clr", 32'(ovf), 32'd0);
      hs_obs = 0;
      axis.tready = 1'b1;
      repeat (8) step();
      chk("ovf_drain", 32'(hs_obs), 32'd4);

      // Random backpressure; the model tracks drops and order.
      rand_ready = 1'b1;
      for (int i = 0; i < 50; i++)
         strobe(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom), 12'($urandom));
      rand_ready = 1'b0;
      axis.tready = 1'b1;
      repeat (8) step();
      chk("rand_drained", 32'(axis.tvalid), 32'd0);

      // Reset with words queued and the packet counter mid-way.
      do_reset();
      axis.tready = 1'b1;
      for (int i = 0; i < 2; i++) strobe(1'b1, 1'b0, 12'($urandom), 12'($urandom));
      axis.tready = 1'b0;
      for (int i = 0; i < 3; i++) strobe(1'b0, 1'b1, 12'($urandom), 12'($urandom));
      chk("mid_queued", 32'(axis.tvalid), 32'd1);
      do_reset();
      chk("mid_valid", 32'(axis.tvalid), 32'd0);
      axis.tready = 1'b1;
      hs_obs = 0; last_obs = 0;
      for (int i = 0; i < 3; i++) strobe(1'b1, 1'b1, 12'($urandom), 12'($urandom));
      chk("mid_nolast", 32'(last_obs), 32'd0);
      strobe(1'b1, 1'b1, 12'($urandom), 12'($urandom));
      repeat (2) step();
      chk("mid_beats", 32'(hs_obs), 32'd4);
      chk("mid_last", 32'(last_obs), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
